// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
// Definitions shared by the data-memory arbiter and its timeout counter:
//   arb_state_t : arbiter FSM states (IDLE, REQ, RESP)
//   CORE0/CORE1 : core index constants, also the encoding of owner/prio
//   cnt_width() : width of a counter that must hold 0..timeout (min 1 bit)
// ----------------------------------------------------------------------------
package riscv_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic CORE0 = 1'b0;
    localparam logic CORE1 = 1'b1;

    // $clog2(1) is 0, so a disabled timeout still gets a 1-bit counter.
    function automatic int cnt_width(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// ----------------------------------------------------------------------------
// arb_timeout_counter
// Counts cycles spent waiting for a memory response and flags when the
// count reaches TIMEOUT. The count saturates at TIMEOUT instead of wrapping.
// TIMEOUT = 0 disables the check (expired never asserts).
// Ports:
//   CLK     in  clock
//   RES_N   in  synchronous active-low reset
//   clr     in  clear the count (takes priority over en)
//   en      in  count one cycle
//   expired out count has reached TIMEOUT
// ----------------------------------------------------------------------------
module arb_timeout_counter
    import riscv_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic CLK,
    input  logic RES_N,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int                 CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0]   LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (!RES_N) begin
            r_count <= '0;
        end else if (clr) begin
            r_count <= '0;
        end else if (en && (r_count != LIMIT)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (TIMEOUT != 0) && (r_count == LIMIT);

endmodule

// File: rtl/data_mem_arbiter.sv
// ----------------------------------------------------------------------------
// data_mem_arbiter
// Shares one data-memory port between two cores. Each core uses a
// req/gnt/r_valid handshake; the arbiter latches one winning request,
// forwards it to memory, and returns the grant and response to that core.
// Round-robin between simultaneous requesters, one transaction in flight,
// and a response timeout that completes the transaction with rdata = 0.
// Ports:
//   CLK, RES_N                  clock, synchronous active-low reset
//   cN_data_req/we/addr/wdata   core N request (held until cN_data_gnt)
//   cN_data_gnt                 core N grant pulse (same cycle as mem_gnt)
//   cN_data_r_valid, cN_rdata   core N response pulse and load data
//   mem_req/we/addr/wdata       memory request side (zero outside REQ)
//   mem_gnt, mem_r_valid, mem_rdata  memory handshake inputs
//   owner                       core currently being served (debug)
//   busy                        transaction in progress (REQ or RESP)
//   timeout_err                 pulse when a response times out
// ----------------------------------------------------------------------------
module data_mem_arbiter
    import riscv_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              CLK,
    input  logic              RES_N,
    input  logic              c0_data_req,
    input  logic              c0_data_we,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_wdata,
    output logic              c0_data_gnt,
    output logic              c0_data_r_valid,
    output logic [DATA_W-1:0] c0_rdata,
    input  logic              c1_data_req,
    input  logic              c1_data_we,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_wdata,
    output logic              c1_data_gnt,
    output logic              c1_data_r_valid,
    output logic [DATA_W-1:0] c1_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_gnt,
    input  logic              mem_r_valid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy,
    output logic              timeout_err
);

    arb_state_t        r_state, w_state_next;
    logic              r_prio, w_prio_next;
    logic              r_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_win;
    logic              w_latch;
    logic              w_gnt;
    logic              w_rvalid;
    logic [DATA_W-1:0] w_rdata;
    logic              w_timeout;
    logic              w_cnt_clr;
    logic              w_cnt_en;
    logic              w_expired;

    // Per-core views so the request mux and response demux index by core.
    logic [1:0]        w_core_req;
    logic [1:0]        w_core_we;
    logic [ADDR_W-1:0] w_core_addr  [2];
    logic [DATA_W-1:0] w_core_wdata [2];
    logic [1:0]        w_core_gnt;
    logic [1:0]        w_core_rvalid;
    logic [DATA_W-1:0] w_core_rdata [2];

    assign w_core_req      = {c1_data_req, c0_data_req};
    assign w_core_we       = {c1_data_we,  c0_data_we};
    assign w_core_addr[0]  = c0_addr;
    assign w_core_addr[1]  = c1_addr;
    assign w_core_wdata[0] = c0_wdata;
    assign w_core_wdata[1] = c1_wdata;

    arb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .CLK     (CLK),
        .RES_N   (RES_N),
        .clr     (w_cnt_clr),
        .en      (w_cnt_en),
        .expired (w_expired)
    );

    // Winner: a lone requester wins outright; on a tie, prio decides.
    always_comb begin
        if (w_core_req == 2'b11) begin
            w_win = r_prio;
        end else begin
            w_win = w_core_req[CORE1] ? CORE1 : CORE0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_prio_next  = r_prio;
        w_latch      = 1'b0;
        w_gnt        = 1'b0;
        w_rvalid     = 1'b0;
        w_rdata      = '0;
        w_timeout    = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (|w_core_req) begin
                    w_latch      = 1'b1;
                    w_state_next = REQ;
                end
            end
            REQ: begin
                if (mem_gnt) begin
                    w_gnt        = 1'b1;
                    w_cnt_clr    = 1'b1;
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_cnt_en = 1'b1;
                // A real response wins over a timeout landing in the same cycle.
                if (mem_r_valid) begin
                    w_rvalid     = 1'b1;
                    w_rdata      = mem_rdata;
                    w_prio_next  = ~r_owner;
                    w_state_next = IDLE;
                end else if (w_expired) begin
                    w_rvalid     = 1'b1;
                    w_timeout    = 1'b1;
                    w_prio_next  = ~r_owner;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RES_N) begin
            r_state <= IDLE;
            r_prio  <= CORE0;
            r_owner <= CORE0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_next;
            r_prio  <= w_prio_next;
            if (w_latch) begin
                r_owner <= w_win;
                r_we    <= w_core_we[w_win];
                r_addr  <= w_core_addr[w_win];
                r_wdata <= w_core_wdata[w_win];
            end
        end
    end

    // Grant and response go only to the owner; rdata is forced to zero
    // whenever that core's r_valid is low.
    for (genvar gi = 0; gi < 2; gi++) begin : g_core
        assign w_core_gnt[gi]    = w_gnt    && (r_owner == 1'(gi));
        assign w_core_rvalid[gi] = w_rvalid && (r_owner == 1'(gi));
        assign w_core_rdata[gi]  = w_core_rvalid[gi] ? w_rdata : '0;
    end

    assign c0_data_gnt     = w_core_gnt[0];
    assign c0_data_r_valid = w_core_rvalid[0];
    assign c0_rdata        = w_core_rdata[0];
    assign c1_data_gnt     = w_core_gnt[1];
    assign c1_data_r_valid = w_core_rvalid[1];
    assign c1_rdata        = w_core_rdata[1];

    // The memory side is driven only while a request is outstanding.
    assign mem_req     = (r_state == REQ);
    assign mem_we      = mem_req && r_we;
    assign mem_addr    = mem_req ? r_addr  : '0;
    assign mem_wdata   = mem_req ? r_wdata : '0;
    assign owner       = r_owner;
    assign busy        = (r_state != IDLE);
    assign timeout_err = w_timeout;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ----------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed stimulus for data_mem_arbiter (TIMEOUT = 4). Expected core-side
// events are queued before each scenario; a negedge monitor pops and checks
// them as the DUT produces grants and responses. A small memory model
// answers requests with configurable grant/response latency.
// ----------------------------------------------------------------------------
module tb_data_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RES_N;
    logic [1:0]  req, we;
    logic [31:0] c0_addr, c0_wdata, c1_addr, c1_wdata;
    logic        c0_data_gnt, c1_data_gnt, c0_data_r_valid, c1_data_r_valid;
    logic [31:0] c0_rdata, c1_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_r_valid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        owner, busy, timeout_err;

    always #5 CLK = ~CLK;

    data_mem_arbiter #(
        .ADDR_W (32),
        .DATA_W (32),
        .TIMEOUT(4)
    ) dut (
        .CLK             (CLK),
        .RES_N           (RES_N),
        .c0_data_req     (req[0]),
        .c0_data_we      (we[0]),
        .c0_addr         (c0_addr),
        .c0_wdata        (c0_wdata),
        .c0_data_gnt     (c0_data_gnt),
        .c0_data_r_valid (c0_data_r_valid),
        .c0_rdata        (c0_rdata),
        .c1_data_req     (req[1]),
        .c1_data_we      (we[1]),
        .c1_addr         (c1_addr),
        .c1_wdata        (c1_wdata),
        .c1_data_gnt     (c1_data_gnt),
        .c1_data_r_valid (c1_data_r_valid),
        .c1_rdata        (c1_rdata),
        .mem_req         (mem_req),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_gnt         (mem_gnt),
        .mem_r_valid     (mem_r_valid),
        .mem_rdata       (mem_rdata),
        .owner           (owner),
        .busy            (busy),
        .timeout_err     (timeout_err)
    );

    typedef struct packed {
        logic        is_rv;
        logic        core;
        logic [31:0] data;
        logic        tmo;
    } ev_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_ev_t;

    ev_t     exp_q[$];
    mem_ev_t mem_log[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int last_gnt_cyc = 0;
    int last_rv_cyc  = 0;
    int tmo_cnt      = 0;

    // memory model configuration
    int   gnt_lat  = 0;
    int   rv_lat   = 1;
    logic rv_never = 1'b0;
    logic stray_rv = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Memory contents seen by loads: one fixed word, otherwise an address tag.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h100) ? 32'hDEADBEEF : (a ^ 32'hA5A5_0000);
    endfunction

    function automatic void push_gnt(input logic c);
        exp_q.push_back('{is_rv: 1'b0, core: c, data: 32'h0, tmo: 1'b0});
    endfunction

    function automatic void push_rv(input logic c, input logic [31:0] d, input logic t);
        exp_q.push_back('{is_rv: 1'b1, core: c, data: d, tmo: t});
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_tests++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic check_idle(input string name);
        chk({name, "_ctrl"}, 64'({mem_req, mem_we, owner, busy, timeout_err,
                                  c0_data_gnt, c1_data_gnt, c0_data_r_valid, c1_data_r_valid}), 64'd0);
        chk({name, "_bus"},   {mem_addr, mem_wdata}, 64'd0);
        chk({name, "_rdata"}, {c0_rdata, c1_rdata},  64'd0);
    endtask

    task automatic chk_mem(input string name, input logic w, input logic [31:0] a, input logic [31:0] d);
        mem_ev_t m;
        if (mem_log.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: no memory transaction logged, expected addr %0h", name, a);
        end else begin
            m = mem_log.pop_front();
            chk(name, {m.we, m.addr, m.wdata}, {w, a, d});
        end
    endtask

    // Core driver: raise req, wait (bounded) for gnt, drop req after the edge.
    // lat counts the cycles observed before the grant cycle.
    task automatic core_req(input int c, input logic w, input logic [31:0] a,
                            input logic [31:0] d, output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        req[c] = 1'b1;
        we[c]  = w;
        if (c == 0) begin c0_addr = a; c0_wdata = d; end
        else        begin c1_addr = a; c1_wdata = d; end
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if ((c == 0) ? c0_data_gnt : c1_data_gnt) begin
                got = 1'b1;
                break;
            end
            lat++;
        end
        n_tests++;
        if (!got) begin
            n_fail++;
            $display("FAIL core%0d_gnt_wait: got no grant expected grant within 60 cycles", c);
        end
        @(posedge CLK);
        #1;
        req[c] = 1'b0;
        we[c]  = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            @(negedge CLK);
        end
        chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
        tick(1);
    endtask

    // Memory model: grant after gnt_lat stalled cycles, respond rv_lat cycles
    // into RESP. stray_rv injects mem_r_valid while the arbiter is not in RESP.
    initial begin : mem_model
        int          m_st;
        int          m_cnt;
        logic [31:0] m_addr;
        m_st = 0; m_cnt = 0; m_addr = '0;
        mem_gnt = 1'b0; mem_r_valid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge CLK);
            #1;
            mem_gnt = 1'b0; mem_r_valid = 1'b0; mem_rdata = '0;
            if (m_st == 2 && !busy)    m_st = 0;
            if (m_st == 1 && !mem_req) m_st = 0;
            if (m_st == 0 && mem_req) begin
                m_st = 1; m_cnt = 0; m_addr = mem_addr;
            end
            if (m_st == 1) begin
                if (m_cnt == gnt_lat) begin
                    mem_gnt = 1'b1; m_st = 2; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end else if (m_st == 2) begin
                m_cnt++;
                if (!rv_never && m_cnt == rv_lat) begin
                    mem_r_valid = 1'b1;
                    mem_rdata   = mem_word(m_addr);
                    m_st        = 0;
                end
            end
            if (stray_rv && (mem_req || !busy)) begin
                mem_r_valid = 1'b1;
                mem_rdata   = 32'hBAD0BAD0;
            end
        end
    end

    // Monitor: pops the scoreboard on every grant / response.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_addr  = '0;

    always @(negedge CLK) begin : monitor
        ev_t         e;
        logic        g, v;
        logic [31:0] rd;
        for (int c = 0; c < 2; c++) begin
            g  = (c == 0) ? c0_data_gnt     : c1_data_gnt;
            v  = (c == 0) ? c0_data_r_valid : c1_data_r_valid;
            rd = (c == 0) ? c0_rdata        : c1_rdata;
            if (g === 1'b1) begin
                last_gnt_cyc = cyc;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL gnt_core%0d: got unexpected grant expected none", c);
                end else begin
                    e = exp_q.pop_front();
                    if (e.is_rv || e.core != 1'(c)) begin
                        n_fail++;
                        $display("FAIL gnt_core%0d: got grant to core%0d expected %s to core%0d",
                                 c, c, e.is_rv ? "r_valid" : "grant", e.core);
                    end
                end
                chk($sformatf("gnt_owner_core%0d", c), 64'(owner), 64'(c));
            end
            if (v === 1'b1) begin
                last_rv_cyc = cyc;
                if (timeout_err === 1'b1) tmo_cnt++;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rv_core%0d: got unexpected r_valid rdata=%0h expected none", c, rd);
                end else begin
                    e = exp_q.pop_front();
                    if (!e.is_rv || e.core != 1'(c) || e.data !== rd || e.tmo !== timeout_err) begin
                        n_fail++;
                        $display("FAIL rv_core%0d: got rdata=%0h tmo=%0b expected %s core%0d rdata=%0h tmo=%0b",
                                 c, rd, timeout_err, e.is_rv ? "r_valid" : "grant", e.core, e.data, e.tmo);
                    end
                end
            end else if (v === 1'b0 && rd !== 32'h0 && RES_N === 1'b1) begin
                n_fail++;
                $display("FAIL rdata_idle_core%0d: got %0h expected 0", c, rd);
            end
        end
        if (timeout_err === 1'b1 && !(c0_data_r_valid === 1'b1 || c1_data_r_valid === 1'b1)) begin
            n_fail++;
            $display("FAIL timeout_err_alone: got timeout_err=1 expected 0 without r_valid");
        end
        if ((mem_req && mem_gnt) === 1'b1 || (c0_data_gnt | c1_data_gnt) === 1'b1) begin
            chk("gnt_with_mem_gnt", 64'(c0_data_gnt | c1_data_gnt), 64'(mem_req && mem_gnt));
        end
        // A request with no grant yet must still be on the bus, unchanged.
        if (prev_stall) begin
            chk("stall_hold", {31'd0, mem_req, mem_addr}, {31'd0, 1'b1, prev_addr});
        end
        prev_stall = (mem_req === 1'b1) && (mem_gnt === 1'b0) && (RES_N === 1'b1);
        prev_addr  = mem_addr;
        if ((mem_req && mem_gnt) === 1'b1) begin
            mem_log.push_back('{we: mem_we, addr: mem_addr, wdata: mem_wdata});
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int lat, lat0, lat1;
        RES_N = 1'b0;
        req = '0; we = '0;
        c0_addr = '0; c0_wdata = '0; c1_addr = '0; c1_wdata = '0;
        tick(2);

        // reset state
        check_idle("reset");
        RES_N = 1'b1;
        tick(1);
        $display("[TB] reset checked");

        // single load from core0
        gnt_lat = 0; rv_lat = 2; rv_never = 1'b0;
        push_gnt(0);
        push_rv(0, 32'hDEADBEEF, 1'b0);
        core_req(0, 1'b0, 32'h100, 32'h0, lat);
        chk("load_gnt_latency", 64'(lat), 64'd1);
        drain("load");
        chk("load_rv_delay", 64'(last_rv_cyc - last_gnt_cyc), 64'd2);
        chk_mem("load_mem", 1'b0, 32'h100, 32'h0);
        $display("[TB] single load done");

        // contention right after reset: core0 first, then core1's store
        RES_N = 1'b0; tick(1); RES_N = 1'b1; tick(1);
        rv_lat = 1;
        push_gnt(0); push_rv(0, 32'hA5A50300, 1'b0);
        push_gnt(1); push_rv(1, 32'hA5A50200, 1'b0);
        fork
            core_req(0, 1'b0, 32'h300, 32'h11, lat0);
            core_req(1, 1'b1, 32'h200, 32'h55, lat1);
        join
        drain("contend");
        chk_mem("contend_mem0", 1'b0, 32'h300, 32'h11);
        chk_mem("contend_mem1", 1'b1, 32'h200, 32'h55);
        // prio returned to core0 after core1 was served
        push_gnt(0); push_rv(0, 32'hA5A50304, 1'b0);
        push_gnt(1); push_rv(1, 32'hA5A50204, 1'b0);
        fork
            core_req(0, 1'b0, 32'h304, 32'h0, lat0);
            core_req(1, 1'b0, 32'h204, 32'h0, lat1);
        join
        drain("contend_prio");
        chk_mem("prio_mem0", 1'b0, 32'h304, 32'h0);
        chk_mem("prio_mem1", 1'b0, 32'h204, 32'h0);
        $display("[TB] contention done");

        // fairness: both cores keep requesting for six transactions
        for (int i = 0; i < 3; i++) begin
            push_gnt(0); push_rv(0, mem_word(32'h1000 + 32'(8 * i)), 1'b0);
            push_gnt(1); push_rv(1, mem_word(32'h2000 + 32'(8 * i)), 1'b0);
        end
        fork
            begin
                int l;
                for (int i = 0; i < 3; i++) core_req(0, 1'b0, 32'h1000 + 32'(8 * i), 32'h0, l);
            end
            begin
                int l;
                for (int i = 0; i < 3; i++) core_req(1, 1'b0, 32'h2000 + 32'(8 * i), 32'h0, l);
            end
        join
        drain("fair");
        for (int i = 0; i < 3; i++) begin
            chk_mem($sformatf("fair_mem0_%0d", i), 1'b0, 32'h1000 + 32'(8 * i), 32'h0);
            chk_mem($sformatf("fair_mem1_%0d", i), 1'b0, 32'h2000 + 32'(8 * i), 32'h0);
        end
        $display("[TB] fairness done");

        // mem_gnt stall with stray r_valid in IDLE/REQ
        gnt_lat = 5; rv_lat = 1; stray_rv = 1'b1;
        push_gnt(1); push_rv(1, 32'hA5A50400, 1'b0);
        core_req(1, 1'b1, 32'h400, 32'hCAFE0001, lat);
        stray_rv = 1'b0;
        chk("stall_gnt_latency", 64'(lat), 64'd6);
        drain("stall");
        chk_mem("stall_mem", 1'b1, 32'h400, 32'hCAFE0001);
        $display("[TB] gnt stall done");

        // response timeout, then a stray r_valid that must be ignored
        gnt_lat = 0; rv_never = 1'b1; tmo_cnt = 0;
        push_gnt(0); push_rv(0, 32'h0, 1'b1);
        core_req(0, 1'b0, 32'h500, 32'h0, lat);
        drain("timeout");
        chk("timeout_delay", 64'(last_rv_cyc - last_gnt_cyc), 64'd5);
        chk("timeout_pulses", 64'(tmo_cnt), 64'd1);
        stray_rv = 1'b1;
        tick(4);
        stray_rv = 1'b0;
        tick(1);
        chk("timeout_pulses_after_stray", 64'(tmo_cnt), 64'd1);
        chk("busy_after_stray", 64'(busy), 64'd0);
        chk_mem("timeout_mem", 1'b0, 32'h500, 32'h0);
        $display("[TB] timeout done");

        // reset during RESP, then a fresh transaction
        rv_never = 1'b1;
        push_gnt(0);
        core_req(0, 1'b1, 32'h600, 32'h77, lat);
        RES_N = 1'b0;
        tick(1);
        check_idle("midreset");
        RES_N = 1'b1;
        tick(2);
        chk("midreset_no_events", 64'(exp_q.size()), 64'd0);
        chk_mem("midreset_mem", 1'b1, 32'h600, 32'h77);
        rv_never = 1'b0; rv_lat = 1;
        push_gnt(0); push_rv(0, 32'hA5A50604, 1'b0);
        core_req(0, 1'b0, 32'h604, 32'h0, lat);
        chk("after_reset_latency", 64'(lat), 64'd1);
        drain("after_reset");
        chk_mem("after_reset_mem", 1'b0, 32'h604, 32'h0);
        $display("[TB] reset mid-op done");

        tick(3);
        chk("final_exp_empty", 64'(exp_q.size()), 64'd0);
        chk("final_memlog_empty", 64'(mem_log.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
